// File: rtl/cu_data_read_engine_control_mc_pkg.sv
// Shared types, constants and helpers for the multi-channel CU read engine control.
package cu_data_read_engine_control_mc_pkg;

  localparam int ARRAY_SIZE_BITS     = 32;
  localparam int CACHELINE_SIZE      = 128;
  localparam int CACHELINE_ARRAY_NUM = 32;
  localparam int CHANNEL_TAG_BITS    = 3;
  localparam int OUTSTANDING_BITS    = 16;
  localparam logic [7:0] DATA_READ_CONTROL_ID = 8'h02;

  typedef enum logic [2:0] {
    RD_MC_IDLE,
    RD_MC_SETUP,
    RD_MC_ISSUE,
    RD_MC_DRAIN,
    RD_MC_DONE
  } read_mc_state;

  typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE} command_type;
  typedef enum logic [1:0] {STRUCT_INVALID, READ_DATA, WRITE_DATA} array_struct_type;
  typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_behavior_t;
  typedef enum logic [12:0] {
    NO_CMD     = 13'h0000,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    READ_PNA   = 13'h0E00
  } afu_command_t;

  typedef struct packed {
    logic [7:0]                 cu_id;
    command_type                cmd_type;
    logic [7:0]                 cacheline_offest;
    logic [ARRAY_SIZE_BITS-1:0] real_size;
    logic [63:0]                address_offest;
    array_struct_type           array_struct;
    trans_order_behavior_t      abt;
  } CommandTagLine;

  typedef struct packed {
    logic                  valid;
    afu_command_t          command;
    logic [63:0]           address;
    logic [11:0]           size;
    trans_order_behavior_t abt;
    CommandTagLine         cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    CommandTagLine cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  typedef struct packed {
    logic [ARRAY_SIZE_BITS-1:0]  remaining;
    logic [63:0]                 offset;
    logic [OUTSTANDING_BITS-1:0] outstanding;
    logic [63:0]                 base;
  } chan_status_t;

  function automatic trans_order_behavior_t map_CABT(input logic [2:0] abt_cfg);
    case (abt_cfg)
      3'd1:    return ABORT;
      3'd2:    return PAGE;
      3'd3:    return PREF;
      3'd4:    return SPEC;
      default: return STRICT;
    endcase
  endfunction

  // Byte size of a line request; elements are 4 bytes, so a partial line is remaining*4.
  function automatic logic [11:0] cmd_size_calculate(input logic [ARRAY_SIZE_BITS-1:0] remaining);
    if (remaining >= ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM)) return 12'h080;
    return {remaining[9:0], 2'b00};
  endfunction

endpackage

// File: rtl/cu_data_read_engine_control_mc_arb.sv
// Round-robin arbiter: grants the lowest requesting index at or after the pointer, wrapping.
module rr_arbiter_n #(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[PTR_W'(cand)]) begin
        grant[PTR_W'(cand)] = 1'b1;
        grant_idx           = PTR_W'(cand);
        found               = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner, so the winner gets lowest priority next time.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cu_data_read_engine_control_mc.sv
// Multi-channel CU read engine control: round-robin cacheline read issue with a
// per-channel outstanding window, response accounting and job completion tracking.
module cu_data_read_engine_control_mc
  import cu_data_read_engine_control_mc_pkg::*;
#(
  parameter int         NUM_CHANNELS       = 4,
  parameter logic [7:0] CU_READ_CONTROL_ID = DATA_READ_CONTROL_ID,
  parameter int         MAX_OUTSTANDING    = 32
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enabled_in,
  input  logic                                         start_in,
  input  logic [NUM_CHANNELS-1:0]                      chan_enable_in,
  input  logic [NUM_CHANNELS-1:0][63:0]                chan_base_in,
  input  logic [NUM_CHANNELS-1:0][ARRAY_SIZE_BITS-1:0] chan_size_in,
  input  logic [63:0]                                  cu_configure,
  input  BufferStatus                                  read_command_buffer_status,
  input  ResponseBufferLine                            read_response_in,
  output CommandBufferLine                             read_command_out,
  output logic [NUM_CHANNELS-1:0]                      chan_done_out,
  output logic [ARRAY_SIZE_BITS-1:0]                   read_job_counter_done,
  output logic                                         job_done_out,
  output logic                                         resp_error_out
);

  localparam logic [ARRAY_SIZE_BITS-1:0]  LINE_ELEMS = ARRAY_SIZE_BITS'(CACHELINE_ARRAY_NUM);
  localparam logic [OUTSTANDING_BITS-1:0] WINDOW     = OUTSTANDING_BITS'(MAX_OUTSTANDING);

  read_mc_state state, state_next;
  chan_status_t chan_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chan_en_q;

  logic [NUM_CHANNELS-1:0] eligible, grant, resp_hit;
  logic any_remaining, any_outstanding, issue_valid, resp_ok, resp_error_now, active;
  logic [CHANNEL_TAG_BITS-1:0] resp_tag;
  logic [ARRAY_SIZE_BITS-1:0] sel_rem, chunk;
  logic [63:0] sel_base, sel_off;
  logic [7:0] sel_tag;
  CommandBufferLine cmd_next;
  logic cfg_unused;

  assign cfg_unused = ^{cu_configure[63:4], read_command_buffer_status.empty,
                        read_command_buffer_status.full, read_response_in.cmd};

  assign resp_tag = read_response_in.cmd.cacheline_offest[CHANNEL_TAG_BITS-1:0];
  assign active   = (state == RD_MC_ISSUE) || (state == RD_MC_DRAIN) || (state == RD_MC_DONE);

  always_comb begin
    eligible        = '0;
    resp_hit        = '0;
    any_remaining   = 1'b0;
    any_outstanding = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      eligible[ch] = chan_en_q[ch] && (chan_q[ch].remaining != '0) && (chan_q[ch].outstanding < WINDOW);
      resp_hit[ch] = read_response_in.valid && (resp_tag == CHANNEL_TAG_BITS'(ch)) &&
                     (chan_q[ch].outstanding != '0);
      any_remaining   = any_remaining | (chan_q[ch].remaining != '0);
      any_outstanding = any_outstanding | (chan_q[ch].outstanding != '0);
    end
  end

  // A response only counts if its channel actually has something in flight.
  assign resp_ok        = |resp_hit;
  assign resp_error_now = read_response_in.valid && !resp_ok;
  assign issue_valid    = (state == RD_MC_ISSUE) && enabled_in &&
                          !read_command_buffer_status.alfull && (|eligible);

  rr_arbiter_n #(.NUM_REQ(NUM_CHANNELS)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (eligible),
    .advance (issue_valid),
    .grant   (grant)
  );

  always_comb begin
    sel_rem  = '0;
    sel_base = '0;
    sel_off  = '0;
    sel_tag  = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (grant[ch]) begin
        sel_rem  = chan_q[ch].remaining;
        sel_base = chan_q[ch].base;
        sel_off  = chan_q[ch].offset;
        sel_tag  = 8'(ch);
      end
    end
    chunk = (sel_rem > LINE_ELEMS) ? LINE_ELEMS : sel_rem;

    cmd_next = '0;
    if (issue_valid) begin
      cmd_next.valid                = 1'b1;
      cmd_next.address              = sel_base + sel_off;
      cmd_next.abt                  = map_CABT(cu_configure[2:0]);
      cmd_next.cmd.cu_id            = CU_READ_CONTROL_ID;
      cmd_next.cmd.cmd_type         = CMD_READ;
      cmd_next.cmd.array_struct     = READ_DATA;
      cmd_next.cmd.cacheline_offest = sel_tag;
      cmd_next.cmd.real_size        = chunk;
      cmd_next.cmd.address_offest   = sel_off;
      cmd_next.cmd.abt              = map_CABT(cu_configure[2:0]);
      if (cu_configure[3]) begin
        cmd_next.command = READ_CL_S;
        cmd_next.size    = 12'h080;
      end else begin
        cmd_next.command = (sel_rem > chunk) ? READ_CL_NA : READ_PNA;
        cmd_next.size    = cmd_size_calculate(sel_rem);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RD_MC_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_MC_IDLE:  if (start_in) state_next = RD_MC_SETUP;
      RD_MC_SETUP: state_next = RD_MC_ISSUE;
      RD_MC_ISSUE: if (!any_remaining) state_next = RD_MC_DRAIN;
      RD_MC_DRAIN: if (!any_outstanding) state_next = RD_MC_DONE;
      RD_MC_DONE:  if (start_in) state_next = RD_MC_SETUP;
      default:     state_next = RD_MC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chan_en_q             <= '0;
      read_command_out      <= '0;
      chan_done_out         <= '0;
      read_job_counter_done <= '0;
      job_done_out          <= 1'b0;
      resp_error_out        <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) chan_q[ch] <= '0;
    end else begin
      read_command_out <= cmd_next;
      if (resp_error_now) resp_error_out <= 1'b1;
      if (state == RD_MC_SETUP) begin
        chan_en_q             <= chan_enable_in;
        read_job_counter_done <= '0;
        job_done_out          <= 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          chan_q[ch].base        <= chan_base_in[ch];
          chan_q[ch].remaining   <= chan_enable_in[ch] ? chan_size_in[ch] : '0;
          chan_q[ch].offset      <= '0;
          chan_q[ch].outstanding <= '0;
          chan_done_out[ch]      <= !chan_enable_in[ch] || (chan_size_in[ch] == '0);
        end
      end else begin
        if (resp_ok) read_job_counter_done <= read_job_counter_done + read_response_in.cmd.real_size;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (issue_valid && grant[ch]) begin
            chan_q[ch].remaining <= chan_q[ch].remaining - chunk;
            chan_q[ch].offset    <= chan_q[ch].offset + 64'(CACHELINE_SIZE);
          end
          // Simultaneous issue and response on one channel leaves the count unchanged.
          case ({issue_valid && grant[ch], resp_hit[ch]})
            2'b10:   chan_q[ch].outstanding <= chan_q[ch].outstanding + OUTSTANDING_BITS'(1);
            2'b01:   chan_q[ch].outstanding <= chan_q[ch].outstanding - OUTSTANDING_BITS'(1);
            default: ;
          endcase
          if (active && (chan_q[ch].remaining == '0) && (chan_q[ch].outstanding == '0))
            chan_done_out[ch] <= 1'b1;
        end
        if (active) job_done_out <= &chan_done_out;
      end
    end
  end

endmodule

// File: tb/tb_cu_data_read_engine_control_mc.sv
// Scoreboard bench: expected commands are queued per job and compared as the DUT emits them.
module tb_cu_data_read_engine_control_mc;
  import cu_data_read_engine_control_mc_pkg::*;

  localparam logic [7:0] TB_CU_ID = 8'h5A;

  logic clock = 1'b0;
  logic reset, enabled_in, start_in;
  logic [3:0] chan_enable_in;
  logic [3:0][63:0] chan_base_in;
  logic [3:0][ARRAY_SIZE_BITS-1:0] chan_size_in;
  logic [63:0] cu_configure;
  BufferStatus read_command_buffer_status;
  ResponseBufferLine read_response_in;
  CommandBufferLine read_command_out;
  logic [3:0] chan_done_out;
  logic [ARRAY_SIZE_BITS-1:0] read_job_counter_done;
  logic job_done_out, resp_error_out;

  typedef struct {
    logic [63:0] addr;
    logic [7:0] chan;
    logic [31:0] real_size;
    afu_command_t command;
    logic [11:0] size;
    logic [63:0] off;
    trans_order_behavior_t abt;
  } exp_t;

  exp_t exp_q[$];
  int cmd_cycle_q[$];
  int vector_count = 0;
  int miscompare_count = 0;
  int cmd_seen = 0;
  int cycle = 0;

  cu_data_read_engine_control_mc #(
    .NUM_CHANNELS(4), .CU_READ_CONTROL_ID(TB_CU_ID), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .reset(reset), .enabled_in(enabled_in), .start_in(start_in),
    .chan_enable_in(chan_enable_in), .chan_base_in(chan_base_in), .chan_size_in(chan_size_in),
    .cu_configure(cu_configure), .read_command_buffer_status(read_command_buffer_status),
    .read_response_in(read_response_in), .read_command_out(read_command_out),
    .chan_done_out(chan_done_out), .read_job_counter_done(read_job_counter_done),
    .job_done_out(job_done_out), .resp_error_out(resp_error_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] chan_base(input int ch);
    return 64'h1000_0000 + 64'(ch) * 64'h10_0000;
  endfunction

  task automatic push_line(input int ch, input int line, input int total, input logic full_lines,
                           input trans_order_behavior_t abt);
    exp_t e;
    int rem, chunk;
    rem = total - line * 32;
    chunk = (rem > 32) ? 32 : rem;
    e.addr = chan_base(ch) + 64'(line * 128);
    e.chan = 8'(ch);
    e.real_size = 32'(chunk);
    e.off = 64'(line * 128);
    e.abt = abt;
    if (full_lines) begin
      e.command = READ_CL_S;
      e.size = 12'h080;
    end else begin
      e.command = (rem > chunk) ? READ_CL_NA : READ_PNA;
      e.size = (rem >= 32) ? 12'h080 : 12'(rem * 4);
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (read_command_out.valid) begin
      cmd_seen++;
      cmd_cycle_q.push_back(cycle);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_cmd", 64'(read_command_out.address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("cmd_addr", read_command_out.address, e.addr);
        checkOutput("cmd_chan", 64'(read_command_out.cmd.cacheline_offest), 64'(e.chan));
        checkOutput("cmd_real_size", 64'(read_command_out.cmd.real_size), 64'(e.real_size));
        checkOutput("cmd_command", 64'(read_command_out.command), 64'(e.command));
        checkOutput("cmd_size", 64'(read_command_out.size), 64'(e.size));
        checkOutput("cmd_offset", read_command_out.cmd.address_offest, e.off);
        checkOutput("cmd_abt", 64'(read_command_out.abt), 64'(e.abt));
        checkOutput("cmd_tag_abt", 64'(read_command_out.cmd.abt), 64'(e.abt));
        checkOutput("cmd_cu_id", 64'(read_command_out.cmd.cu_id), 64'(TB_CU_ID));
        checkOutput("cmd_type", 64'(read_command_out.cmd.cmd_type), 64'(CMD_READ));
        checkOutput("cmd_struct", 64'(read_command_out.cmd.array_struct), 64'(READ_DATA));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] en, input logic [63:0] cfg, input int size);
    chan_enable_in = en;
    cu_configure = cfg;
    for (int ch = 0; ch < 4; ch++) begin
      chan_base_in[ch] = chan_base(ch);
      chan_size_in[ch] = 32'(size);
    end
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_resp(input int ch, input int rs, input int n);
    for (int i = 0; i < n; i++) begin
      read_response_in = '0;
      read_response_in.valid = 1'b1;
      read_response_in.cmd.cacheline_offest = 8'(ch);
      read_response_in.cmd.real_size = 32'(rs);
      @(posedge clock); #1;
    end
    read_response_in = '0;
  endtask

  task automatic wait_cmds(input int target, input int budget);
    int n = 0;
    while (cmd_seen < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (cmd_seen < target) checkOutput("cmd_timeout", 64'(cmd_seen), 64'(target));
  endtask

  task automatic wait_job_done(input string tag, input int budget);
    int n = 0;
    while (!job_done_out && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput(tag, 64'(job_done_out), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, c0, c1;
    reset = 1'b1;
    enabled_in = 1'b1;
    start_in = 1'b0;
    chan_enable_in = '0;
    chan_base_in = '0;
    chan_size_in = '0;
    cu_configure = '0;
    read_command_buffer_status = '0;
    read_response_in = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("reset_cmd_valid", 64'(read_command_out.valid), 64'd0);
    checkOutput("reset_chan_done", 64'(chan_done_out), 64'd0);
    checkOutput("reset_job_done", 64'(job_done_out), 64'd0);
    checkOutput("reset_counter", 64'(read_job_counter_done), 64'd0);
    checkOutput("reset_resp_error", 64'(resp_error_out), 64'd0);

    $display("[TB] single channel, partial last line");
    for (int l = 0; l < 4; l++) push_line(0, l, 101, 1'b0, STRICT);
    base = cmd_seen;
    applyStimulus(4'b0001, 64'h0, 101);
    wait_cmds(base + 4, 50);
    idle(5);
    checkOutput("t1_cmd_count", 64'(cmd_seen - base), 64'd4);
    checkOutput("t1_chan_done_pre", 64'(chan_done_out), 64'hE);
    send_resp(0, 32, 3);
    send_resp(0, 5, 1);
    wait_job_done("t1_job_done", 50);
    checkOutput("t1_counter", 64'(read_job_counter_done), 64'd101);
    checkOutput("t1_chan_done", 64'(chan_done_out), 64'hF);
    checkOutput("t1_resp_error", 64'(resp_error_out), 64'd0);

    $display("[TB] four channels round-robin");
    do_reset();
    for (int l = 0; l < 2; l++)
      for (int ch = 0; ch < 4; ch++) push_line(ch, l, 64, 1'b1, PAGE);
    base = cmd_seen;
    applyStimulus(4'hF, 64'hA, 64);
    wait_cmds(base + 8, 50);
    checkOutput("t2_consecutive", 64'(cmd_cycle_q[base + 7] - cmd_cycle_q[base]), 64'd7);
    for (int ch = 0; ch < 4; ch++) send_resp(ch, 32, 2);
    wait_job_done("t2_job_done", 50);
    checkOutput("t2_counter", 64'(read_job_counter_done), 64'd256);

    $display("[TB] outstanding window");
    do_reset();
    for (int l = 0; l < 4; l++) push_line(0, l, 256, 1'b0, STRICT);
    base = cmd_seen;
    applyStimulus(4'b0001, 64'h0, 256);
    wait_cmds(base + 4, 50);
    idle(10);
    checkOutput("t3_stall_count", 64'(cmd_seen - base), 64'd4);
    push_line(0, 4, 256, 1'b0, STRICT);
    send_resp(0, 32, 1);
    idle(10);
    checkOutput("t3_one_more", 64'(cmd_seen - base), 64'd5);

    $display("[TB] same-cycle issue and response, stray response");
    push_line(0, 5, 256, 1'b0, STRICT);
    push_line(0, 6, 256, 1'b0, STRICT);
    send_resp(0, 32, 2);
    idle(10);
    checkOutput("t5_window_kept", 64'(cmd_seen - base), 64'd7);
    checkOutput("t5_error_before", 64'(resp_error_out), 64'd0);
    send_resp(2, 32, 1);
    idle(1);
    checkOutput("t5_stray_error", 64'(resp_error_out), 64'd1);
    checkOutput("t5_stray_counter", 64'(read_job_counter_done), 64'd96);
    push_line(0, 7, 256, 1'b0, STRICT);
    send_resp(0, 32, 4);
    wait_cmds(base + 8, 50);
    send_resp(0, 32, 1);
    wait_job_done("t5_job_done", 50);
    checkOutput("t5_counter", 64'(read_job_counter_done), 64'd256);

    $display("[TB] almost-full back-pressure");
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int ch = 0; ch < 2; ch++) push_line(ch, l, 128, 1'b0, STRICT);
    base = cmd_seen;
    applyStimulus(4'b0011, 64'h0, 128);
    wait_cmds(base + 3, 50);
    read_command_buffer_status.alfull = 1'b1;
    @(posedge clock); #1;
    c0 = cmd_seen;
    repeat (9) @(posedge clock);
    #1;
    read_command_buffer_status.alfull = 1'b0;
    @(posedge clock); #1;
    c1 = cmd_seen;
    checkOutput("t4_alfull_quiet", 64'(c1), 64'(c0));
    wait_cmds(base + 8, 50);
    for (int ch = 0; ch < 2; ch++) send_resp(ch, 32, 4);
    wait_job_done("t4_job_done", 50);
    checkOutput("t4_counter", 64'(read_job_counter_done), 64'd256);

    $display("[TB] reset mid-job then clean rerun");
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int ch = 0; ch < 2; ch++) push_line(ch, l, 128, 1'b0, STRICT);
    base = cmd_seen;
    applyStimulus(4'b0011, 64'h0, 128);
    wait_cmds(base + 2, 50);
    do_reset();
    checkOutput("t6_cmd_valid", 64'(read_command_out.valid), 64'd0);
    checkOutput("t6_cmd_addr", read_command_out.address, 64'd0);
    checkOutput("t6_chan_done", 64'(chan_done_out), 64'd0);
    checkOutput("t6_job_done", 64'(job_done_out), 64'd0);
    checkOutput("t6_counter", 64'(read_job_counter_done), 64'd0);
    checkOutput("t6_resp_error", 64'(resp_error_out), 64'd0);
    send_resp(0, 32, 1);
    idle(1);
    checkOutput("t6_inflight_error", 64'(resp_error_out), 64'd1);
    checkOutput("t6_inflight_counter", 64'(read_job_counter_done), 64'd0);
    for (int l = 0; l < 2; l++)
      for (int ch = 0; ch < 2; ch++) push_line(ch, l, 40, 1'b0, STRICT);
    base = cmd_seen;
    applyStimulus(4'b0011, 64'h0, 40);
    wait_cmds(base + 4, 50);
    send_resp(0, 32, 1);
    send_resp(1, 32, 1);
    send_resp(0, 8, 1);
    send_resp(1, 8, 1);
    wait_job_done("t6_job_done", 50);
    checkOutput("t6_rerun_counter", 64'(read_job_counter_done), 64'd80);
    checkOutput("t6_rerun_chan_done", 64'(chan_done_out), 64'hF);

    idle(3);
    checkOutput("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
